// File: rtl/jk_updown_counter.sv
// Mod-MOD up/down counter built from WIDTH JK cells with per-bit J/K excitation.
// Optional JK_CNT_GRAY_OUT_EN adds a registered Gray-code copy of the count (q_gray).
module jk_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k
`ifdef JK_CNT_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    generate
        if (WIDTH < 2 || MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_param
            $error("jk_updown_counter: illegal WIDTH/MOD combination");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic             din_over;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] q_next;

    assign din_over = {1'b0, din} >= MOD_EXT;

    // Bit i toggles up when all lower bits are 1, down when all lower bits are 0.
    always_comb begin : toggle_masks
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        t_up  = '0;
        t_dn  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = ones;
            t_dn[i] = zeros;
            ones    = ones & q[i];
            zeros   = zeros & ~q[i];
        end
    end

    always_comb begin : excitation
        logic [WIDTH-1:0] load_val;
        load_val = din_over ? MAX_CNT : din;
        jk_j     = '0;
        jk_k     = '0;
        if (load) begin
            jk_j = load_val;
            jk_k = ~load_val;
        end else if (en) begin
            if (up) begin
                // q >= MAX_CNT also catches out-of-range states and forces them to 0.
                if (q >= MAX_CNT) begin
                    jk_j = '0;
                    jk_k = '1;
                end else begin
                    jk_j = t_up;
                    jk_k = t_up;
                end
            end else begin
                if (q == '0) begin
                    jk_j = MAX_CNT;
                    jk_k = ~MAX_CNT;
                end else begin
                    jk_j = t_dn;
                    jk_k = t_dn;
                end
            end
        end
    end

    assign q_next = (jk_j & ~q) | (~jk_k & q);
    assign tc     = en & ~load & (up ? (q == MAX_CNT) : (q == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q        <= '0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            load_err <= load & din_over;
        end
    end

`ifdef JK_CNT_GRAY_OUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_gray <= '0;
        end else begin
            q_gray <= to_gray(q_next);
        end
    end
`endif

endmodule
